// File: rtl/gsk_burst_sequencer.sv
// gsk_burst_sequencer
//   Table-driven burst scheduler. Each table entry holds {last, lane mask, len};
//   a frame is LEAD silence, then every entry played as len HIGH/LOW pairs,
//   then TAIL silence. All outputs are registered.
//   Optional feature: define GSK_SEQ_FRAME_CNT_EN to add the frame_cnt output.
module gsk_burst_sequencer #(
   parameter int LANES    = 7,
   parameter int DEPTH    = 16,
   parameter int LEAD_CYC = 15,
   parameter int TAIL_CYC = 60,
   parameter int AW       = $clog2(DEPTH),
   parameter int EW       = LANES + 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             loop,
   input  logic             cfg_we,
   input  logic [AW-1:0]    cfg_addr,
   input  logic [EW-1:0]    cfg_wdata,
   output logic             cfg_err,
   output logic             busy,
   output logic             frame_done,
   output logic [AW-1:0]    cur_idx,
   output logic [LANES-1:0] lanes
`ifdef GSK_SEQ_FRAME_CNT_EN
   ,
   output logic [15:0]      frame_cnt
`endif
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LEAD = 3'd1;
   localparam logic [2:0] S_HIGH = 3'd2;
   localparam logic [2:0] S_LOW  = 3'd3;
   localparam logic [2:0] S_TAIL = 3'd4;

   localparam int CW = 16;
   localparam logic [CW-1:0] LEAD_N   = CW'(LEAD_CYC);
   // A looped frame restarts through one extra cycle, as if start had been
   // sampled right after the tail: the lead phase is one cycle longer.
   localparam logic [CW-1:0] RELOAD_N = CW'(LEAD_CYC + 1);
   localparam logic [CW-1:0] TAIL_N   = CW'(TAIL_CYC);
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   // pattern table, not touched by reset
   logic [EW-1:0]    tbl_q [DEPTH];

   logic [2:0]       state_q, state_d;
   logic [AW-1:0]    cur_idx_q, cur_idx_d;
   logic [7:0]       rep_q, rep_d;       // HIGH/LOW pairs left, current one included
   logic [CW-1:0]    cyc_q, cyc_d;       // LEAD/TAIL cycles left, current one included
   logic             pend_q, pend_d;     // stop seen in HIGH, honoured after the LOW
   logic [LANES-1:0] lanes_q, lanes_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic             start_ok, wr_ok;
   logic [AW-1:0]    ld_idx;
   logic [LANES-1:0] ld_mask, cur_mask;
   logic [7:0]       ld_len;
   logic             frame_end, go_entry, go_end;

   // entry fetch: next entry to load, with bypass of a write accepted this cycle
   always_comb begin
      start_ok = start & ~stop & (state_q == S_IDLE);
      wr_ok    = cfg_we & (state_q == S_IDLE);
      ld_idx   = (state_q == S_LOW) ? cur_idx_q + AW'(1) : '0;
      if (wr_ok && (cfg_addr == ld_idx)) begin
         ld_mask = cfg_wdata[EW-2:8];
         ld_len  = cfg_wdata[7:0];
      end else begin
         ld_mask = tbl_q[ld_idx][EW-2:8];
         ld_len  = tbl_q[ld_idx][7:0];
      end
      cur_mask  = tbl_q[cur_idx_q][EW-2:8];
      frame_end = tbl_q[cur_idx_q][EW-1] | (cur_idx_q == LAST_IDX);
   end

   // sequencer next-state and next-output logic
   always_comb begin
      state_d   = state_q;
      cur_idx_d = cur_idx_q;
      rep_d     = rep_q;
      cyc_d     = cyc_q;
      pend_d    = pend_q;
      lanes_d   = '0;
      done_d    = 1'b0;
      go_entry  = 1'b0;
      go_end    = 1'b0;
      err_d     = cfg_we & (state_q != S_IDLE);

      case (state_q)
         S_IDLE: begin
            cur_idx_d = '0;
            pend_d    = 1'b0;
            if (start_ok) begin
               if (LEAD_CYC == 0) begin
                  go_entry = 1'b1;
               end else begin
                  state_d = S_LEAD;
                  cyc_d   = LEAD_N;
               end
            end
         end
         S_LEAD: begin
            if (stop) begin
               state_d = S_IDLE;
            end else if (cyc_q <= 16'd1) begin
               go_entry = 1'b1;
            end else begin
               cyc_d = cyc_q - 16'd1;
            end
         end
         S_HIGH: begin
            // never cut a pulse short: a stop here waits for the LOW
            state_d = S_LOW;
            if (stop) pend_d = 1'b1;
         end
         S_LOW: begin
            if (stop || pend_q) begin
               state_d   = S_IDLE;
               cur_idx_d = '0;
               pend_d    = 1'b0;
            end else if (rep_q > 8'd1) begin
               state_d = S_HIGH;
               rep_d   = rep_q - 8'd1;
               lanes_d = cur_mask;
            end else if (frame_end) begin
               go_end = 1'b1;
            end else begin
               go_entry = 1'b1;
            end
         end
         S_TAIL: begin
            if (stop) begin
               state_d   = S_IDLE;
               cur_idx_d = '0;
            end else if (cyc_q <= 16'd1) begin
               cur_idx_d = '0;
               if (loop) begin
                  state_d = S_LEAD;
                  cyc_d   = RELOAD_N;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cyc_d = cyc_q - 16'd1;
            end
         end
         default: begin
            state_d   = S_IDLE;
            cur_idx_d = '0;
         end
      endcase

      // start playing entry ld_idx; a zero length is a single silent LOW
      if (go_entry) begin
         cur_idx_d = ld_idx;
         if (ld_len == 8'd0) begin
            state_d = S_LOW;
            rep_d   = 8'd0;
         end else begin
            state_d = S_HIGH;
            rep_d   = ld_len;
            lanes_d = ld_mask;
         end
      end

      // frame complete: pulse done, then tail (or straight on when no tail)
      if (go_end) begin
         done_d = 1'b1;
         if (TAIL_CYC == 0) begin
            cur_idx_d = '0;
            if (loop) begin
               state_d = S_LEAD;
               cyc_d   = RELOAD_N;
            end else begin
               state_d = S_IDLE;
            end
         end else begin
            state_d = S_TAIL;
            cyc_d   = TAIL_N;
         end
      end

      busy_d = (state_d != S_IDLE);
   end

   // state and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cur_idx_q <= '0;
         rep_q     <= '0;
         cyc_q     <= '0;
         pend_q    <= 1'b0;
         lanes_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_idx_q <= cur_idx_d;
         rep_q     <= rep_d;
         cyc_q     <= cyc_d;
         pend_q    <= pend_d;
         lanes_q   <= lanes_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   // table write port, idle only
   always_ff @(posedge clk) begin
      if (rst_n && wr_ok) tbl_q[cfg_addr] <= cfg_wdata;
   end

   assign cfg_err    = err_q;
   assign busy       = busy_q;
   assign frame_done = done_q;
   assign cur_idx    = cur_idx_q;
   assign lanes      = lanes_q;

`ifdef GSK_SEQ_FRAME_CNT_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;

   // completed-frame counter, restarted by each accepted start
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      if (start_ok)    frame_cnt_d = '0;
      else if (done_d) frame_cnt_d = frame_cnt_q + 16'd1;
   end

   // frame counter register
   always_ff @(posedge clk) begin
      if (!rst_n) frame_cnt_q <= '0;
      else        frame_cnt_q <= frame_cnt_d;
   end

   assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_gsk_burst_sequencer.sv
// Directed bench for gsk_burst_sequencer (default parameters).
module tb_gsk_burst_sequencer;
   localparam int AW = 4;
   localparam int EW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0, stop = 1'b0, loop = 1'b0, cfg_we = 1'b0;
   logic [AW-1:0] cfg_addr = '0;
   logic [EW-1:0] cfg_wdata = '0;
   logic          cfg_err, busy, frame_done;
   logic [AW-1:0] cur_idx;
   logic [6:0]    lanes;
`ifdef GSK_SEQ_FRAME_CNT_EN
   logic [15:0]   frame_cnt;
`endif

   int checks = 0;
   int errors = 0;

   logic [6:0]    r_lanes [0:199];
   logic          r_busy  [0:199];
   logic          r_done  [0:199];
   logic          r_err   [0:199];
   logic [AW-1:0] r_idx   [0:199];

   gsk_burst_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .cfg_err(cfg_err), .busy(busy), .frame_done(frame_done),
      .cur_idx(cur_idx), .lanes(lanes)
`ifdef GSK_SEQ_FRAME_CNT_EN
      , .frame_cnt(frame_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Cycle c: outputs sampled at the negedge inside cycle c, then inputs for
   // cycle c applied (seen by the posedge that ends cycle c).
   task automatic record(input int n, input bit do_start, input int stop_at,
                         input int we_at, input logic [AW-1:0] wa,
                         input logic [EW-1:0] wd, input int rst_at);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         r_lanes[c] = lanes;
         r_busy[c]  = busy;
         r_done[c]  = frame_done;
         r_err[c]   = cfg_err;
         r_idx[c]   = cur_idx;
         start      = do_start && (c == 0);
         stop       = (c == stop_at);
         cfg_we     = (c == we_at);
         cfg_addr   = wa;
         cfg_wdata  = wd;
         rst_n      = (c != rst_at);
      end
   endtask

   task automatic write_entry(input logic [AW-1:0] a, input logic [EW-1:0] d);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic load_basic();
      write_entry(4'd0, {1'b0, 7'h7F, 8'd3});
      write_entry(4'd1, {1'b1, 7'h01, 8'd2});
   endtask

   // expected lanes of the basic table, c counted from the start cycle
   function automatic logic [6:0] exp_basic(input int c);
      if (c == 16 || c == 18 || c == 20) return 7'h7F;
      if (c == 22 || c == 24) return 7'h01;
      return 7'h00;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (lanes !== 7'h00) begin errors++; $display("FAIL reset_lanes got %h exp 00", lanes); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", frame_done); end
      checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", cfg_err); end
      checks++; if (cur_idx !== 4'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", cur_idx); end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      logic [6:0] e;
      load_basic();
      record(90, 1'b1, -1, -1, '0, '0, -1);
      for (int c = 0; c < 90; c++) begin
         e = exp_basic(c);
         checks++; if (r_lanes[c] !== e) begin errors++; $display("FAIL basic_lanes c=%0d got %h exp %h", c, r_lanes[c], e); end
         checks++; if (r_done[c] !== (c == 26)) begin errors++; $display("FAIL basic_done c=%0d got %b exp %b", c, r_done[c], c == 26); end
         checks++; if (r_busy[c] !== (c >= 1 && c <= 85)) begin errors++; $display("FAIL basic_busy c=%0d got %b exp %b", c, r_busy[c], (c >= 1 && c <= 85)); end
      end
      checks++; if (r_idx[16] !== 4'd0) begin errors++; $display("FAIL basic_idx16 got %0d exp 0", r_idx[16]); end
      checks++; if (r_idx[22] !== 4'd1) begin errors++; $display("FAIL basic_idx22 got %0d exp 1", r_idx[22]); end
      checks++; if (r_idx[21] !== 4'd0) begin errors++; $display("FAIL basic_idx21 got %0d exp 0", r_idx[21]); end
`ifdef GSK_SEQ_FRAME_CNT_EN
      checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL basic_frame_cnt got %0d exp 1", frame_cnt); end
`endif
   endtask

   task automatic test_loop();
      logic [6:0] e;
      loop = 1'b1;
      record(116, 1'b1, 114, -1, '0, '0, -1);
      loop = 1'b0;
      for (int c = 0; c < 116; c++) begin
         e = (c < 86) ? exp_basic(c) : exp_basic(c - 86);
         checks++; if (r_lanes[c] !== e) begin errors++; $display("FAIL loop_lanes c=%0d got %h exp %h", c, r_lanes[c], e); end
         checks++; if (r_done[c] !== (c == 26 || c == 112)) begin errors++; $display("FAIL loop_done c=%0d got %b", c, r_done[c]); end
      end
      checks++; if (r_busy[86] !== 1'b1) begin errors++; $display("FAIL loop_busy86 got %b exp 1", r_busy[86]); end
      checks++; if (r_busy[114] !== 1'b1) begin errors++; $display("FAIL loop_busy114 got %b exp 1", r_busy[114]); end
      checks++; if (r_busy[115] !== 1'b0) begin errors++; $display("FAIL loop_tail_stop got %b exp 0", r_busy[115]); end
   endtask

   task automatic test_abort();
      logic [6:0] e;
      record(40, 1'b1, 18, -1, '0, '0, -1);
      for (int c = 0; c < 40; c++) begin
         e = (c <= 18) ? exp_basic(c) : 7'h00;
         checks++; if (r_lanes[c] !== e) begin errors++; $display("FAIL abort_lanes c=%0d got %h exp %h", c, r_lanes[c], e); end
         checks++; if (r_done[c] !== 1'b0) begin errors++; $display("FAIL abort_done c=%0d got %b exp 0", c, r_done[c]); end
      end
      checks++; if (r_busy[19] !== 1'b1) begin errors++; $display("FAIL abort_busy19 got %b exp 1", r_busy[19]); end
      checks++; if (r_busy[20] !== 1'b0) begin errors++; $display("FAIL abort_busy20 got %b exp 0", r_busy[20]); end
   endtask

   task automatic test_cfg_guard();
      logic [6:0] e;
      record(90, 1'b1, -1, 5, 4'd0, {1'b0, 7'h2A, 8'd3}, -1);
      for (int c = 0; c < 90; c++) begin
         checks++; if (r_err[c] !== (c == 6)) begin errors++; $display("FAIL cfg_err c=%0d got %b exp %b", c, r_err[c], c == 6); end
      end
      // rerun: the dropped write must not have altered entry 0
      record(30, 1'b1, 28, -1, '0, '0, -1);
      for (int c = 0; c < 27; c++) begin
         e = exp_basic(c);
         checks++; if (r_lanes[c] !== e) begin errors++; $display("FAIL cfg_table c=%0d got %h exp %h", c, r_lanes[c], e); end
      end
   endtask

   task automatic test_start_write();
      record(30, 1'b1, 28, 0, 4'd1, {1'b1, 7'h55, 8'd2}, -1);
      checks++; if (r_lanes[22] !== 7'h55) begin errors++; $display("FAIL startwr_22 got %h exp 55", r_lanes[22]); end
      checks++; if (r_lanes[24] !== 7'h55) begin errors++; $display("FAIL startwr_24 got %h exp 55", r_lanes[24]); end
      checks++; if (r_done[26] !== 1'b1) begin errors++; $display("FAIL startwr_done got %b exp 1", r_done[26]); end
      checks++; if (r_err[1] !== 1'b0) begin errors++; $display("FAIL startwr_err got %b exp 0", r_err[1]); end
      write_entry(4'd1, {1'b1, 7'h01, 8'd2});
   endtask

   task automatic test_edge();
      logic [6:0] e;
      write_entry(4'd0, {1'b0, 7'h00, 8'd0});
      write_entry(4'd1, {1'b0, 7'h04, 8'd1});
      for (int i = 2; i < 16; i++) write_entry(4'(i), 16'h0000);
      record(95, 1'b1, -1, -1, '0, '0, -1);
      for (int c = 0; c < 95; c++) begin
         e = (c == 17) ? 7'h04 : 7'h00;
         checks++; if (r_lanes[c] !== e) begin errors++; $display("FAIL edge_lanes c=%0d got %h exp %h", c, r_lanes[c], e); end
         checks++; if (r_done[c] !== (c == 33)) begin errors++; $display("FAIL edge_done c=%0d got %b exp %b", c, r_done[c], c == 33); end
      end
      checks++; if (r_idx[32] !== 4'd15) begin errors++; $display("FAIL edge_idx32 got %0d exp 15", r_idx[32]); end
      checks++; if (r_idx[19] !== 4'd2) begin errors++; $display("FAIL edge_idx19 got %0d exp 2", r_idx[19]); end
      checks++; if (r_busy[92] !== 1'b1) begin errors++; $display("FAIL edge_busy92 got %b exp 1", r_busy[92]); end
      checks++; if (r_busy[93] !== 1'b0) begin errors++; $display("FAIL edge_busy93 got %b exp 0", r_busy[93]); end
      load_basic();
   endtask

   task automatic test_rst_collision();
      logic [6:0] e;
      record(24, 1'b1, -1, -1, '0, '0, 20);
      checks++; if (r_lanes[20] !== 7'h7F) begin errors++; $display("FAIL rst_pre got %h exp 7F", r_lanes[20]); end
      for (int c = 21; c < 24; c++) begin
         checks++; if (r_lanes[c] !== 7'h00) begin errors++; $display("FAIL rst_lanes c=%0d got %h exp 00", c, r_lanes[c]); end
         checks++; if (r_busy[c] !== 1'b0) begin errors++; $display("FAIL rst_busy c=%0d got %b exp 0", c, r_busy[c]); end
         checks++; if (r_done[c] !== 1'b0) begin errors++; $display("FAIL rst_done c=%0d got %b exp 0", c, r_done[c]); end
         checks++; if (r_err[c] !== 1'b0) begin errors++; $display("FAIL rst_err c=%0d got %b exp 0", c, r_err[c]); end
         checks++; if (r_idx[c] !== 4'd0) begin errors++; $display("FAIL rst_idx c=%0d got %0d exp 0", c, r_idx[c]); end
      end
      // start and stop together while idle: stop wins
      record(20, 1'b1, 0, -1, '0, '0, -1);
      for (int c = 1; c < 20; c++) begin
         checks++; if (r_busy[c] !== 1'b0) begin errors++; $display("FAIL collide_busy c=%0d got %b exp 0", c, r_busy[c]); end
         checks++; if (r_lanes[c] !== 7'h00) begin errors++; $display("FAIL collide_lanes c=%0d got %h exp 00", c, r_lanes[c]); end
      end
      // table survives reset
      record(30, 1'b1, 28, -1, '0, '0, -1);
      for (int c = 0; c < 27; c++) begin
         e = exp_basic(c);
         checks++; if (r_lanes[c] !== e) begin errors++; $display("FAIL rst_table c=%0d got %h exp %h", c, r_lanes[c], e); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_loop();
      test_abort();
      test_cfg_guard();
      test_start_write();
      test_edge();
      test_rst_collision();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gsk_burst_sequencer.md
# gsk_burst_sequencer

- Programmable scheduler that drives a bank of waveform lanes with gated pulse bursts from a small pattern table, one frame per start.
- Replaces the hand-written per-lane delay/repeat stimulus used to paint the GSK glyph on seven waveform lines: each table entry names a lane mask and a burst length, and the block walks the table cycle-accurately.
- Sits between a configuration master, which loads the table and issues start/stop, and the waveform sink, which is the display/dump stage.

## Interface
- LANES, 7, number of output lanes
- DEPTH, 16, pattern table entries; AW = $clog2(DEPTH)
- LEAD_CYC, 15, silent cycles between start and the first entry (0 allowed)
- TAIL_CYC, 60, silent cycles after the last entry of a frame (0 allowed)
- Entry format (EW = LANES+9 bits): [EW-1] last, [EW-2:8] lane mask, [7:0] len
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  single-cycle pulse, begin a frame
- stop  in  1  single-cycle pulse, abort
- loop  in  1  level, repeat frames while high
- cfg_we  in  1  table write strobe
- cfg_addr  in  AW  table write address
- cfg_wdata  in  EW  table write data
- cfg_err  out  1  one-cycle pulse: write rejected
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-cycle pulse at the end of a frame
- cur_idx  out  AW  index of the entry being played (0 when idle)
- lanes  out  LANES  registered burst outputs

## Operation
- Reset values: lanes=0, busy=0, frame_done=0, cfg_err=0, cur_idx=0, state IDLE. Table contents are not cleared by reset.
- States and transitions:
  - IDLE: on start (and no stop in the same cycle), go to LEAD.
  - LEAD: count LEAD_CYC cycles, then go to HIGH of entry 0 (directly if LEAD_CYC=0).
  - HIGH: lanes = mask. Go to LOW.
  - LOW: lanes = 0. After `len` HIGH/LOW pairs, advance to the next entry.
  - A frame ends after an entry with last=1, or after entry DEPTH-1 regardless of its last bit. Then go to TAIL.
  - TAIL: count TAIL_CYC cycles with lanes = 0. Then go to LEAD if loop=1, else to IDLE.
- len=0 consumes exactly one LOW cycle with lanes=0.
- mask=0 yields 2*len silent cycles (gap entry).
- Writes:
  - Accepted only in IDLE.
  - cfg_we while busy: write dropped, cfg_err pulses the next cycle.
  - A write in the same cycle as start is accepted; the frame uses the new data.
- stop:
  - In LEAD or TAIL: immediate.
  - In HIGH: takes effect after the following LOW, so no truncated pulse.
  - Result: lanes=0, go to IDLE. No frame_done on an aborted frame.
- start while busy is ignored. stop together with start in IDLE: stop wins and the block stays IDLE.
- Synchronous reset mid-frame: the next cycle is fully at reset values.

## Timing
- start sampled at cycle T. LEAD occupies T+1 .. T+LEAD_CYC. The first HIGH is visible at T+1+LEAD_CYC.
- Each entry lasts 2*len cycles (1 cycle if len=0). There are no idle cycles between entries.
- frame_done is asserted in the first TAIL cycle, i.e. the cycle after the final LOW. It pulses even when TAIL_CYC=0, in which case it coincides with the next LEAD or IDLE cycle.
- busy drops in the first IDLE cycle.
- cur_idx changes in the same cycle as the first HIGH of the new entry.

## Configuration
- GSK_SEQ_FRAME_CNT_EN:
  - Defined: adds output frame_cnt [15:0], which counts frame_done pulses, wraps at 16'hFFFF→0, and is cleared by reset and by an accepted start.
  - Undefined: the port and its counter are absent; all other behaviour is identical.

## Test plan
- Basic frame, defaults:
  - Stimulus: entry0={0,7'h7F,3}, entry1={1,7'h01,2}, loop=0, start at cycle 0.
  - Required: lanes=7F at 16/18/20; lanes=01 at 22/24; lanes=00 on all other cycles; frame_done at 26; busy low from 86.
- Loop:
  - Stimulus: same table, loop=1.
  - Required: second frame's first HIGH at cycle 102; frame_done at 26 and 112.
- Abort:
  - Stimulus: stop at cycle 18, which is a HIGH cycle.
  - Required: lanes=7F at 18, 00 at 19; IDLE and busy=0 at cycle 20; no frame_done.
- Config guard:
  - Stimulus: cfg_we at cycle 5 while running.
  - Required: cfg_err pulses at cycle 6; the table readback after the frame is unchanged.
- Edge entries:
  - Stimulus: entry0={0,7'h00,0}, entry1={0,7'h04,1}, no last bit set anywhere, DEPTH=16 with entries 2..15 = {0,0,0}.
  - Required: lanes=04 only at cycle 17; the frame ends after entry 15 with frame_done at 33.
- Reset and start/stop collision:
  - Stimulus: rst_n low at cycle 20 of a frame; later, start and stop asserted in the same cycle while IDLE.
  - Required: all outputs at reset values from cycle 21 and the table is preserved; the block stays IDLE after the collision.
